memory_pipe_reg: RTL and testbench
==================================

# memory_pipe_reg

E→M pipeline register and memory-stage control for the 5-stage Y86-64 pipeline. Latches execute-stage results on each clock, holds or bubbles them under hazard-unit control, and drives address, data and read/write strobes into the data memory. Merges the data memory's error flag into the memory-stage status and freezes stores once an exception has been seen.

## Interface
- `ADDR_LIMIT`, 8192: number of valid data-memory words; used only when `MEM_ADDR_CHECK_EN` is defined.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `M_stall` in 1: hold M register contents.
- `M_bubble` in 1: load a NOP bubble.
- `e_stat` in 3: status from execute (1 AOK, 2 HLT, 3 ADR, 4 INS).
- `E_icode` in 4: instruction code.
- `e_Cnd` in 1: condition result.
- `e_valE` in 64: ALU result.
- `E_valA` in 64: operand A / store data.
- `e_dstE` in 4: destination E register id (0xF = none).
- `E_dstM` in 4: destination M register id.
- `W_stat` in 3: status currently in writeback.
- `dmem_error` in 1: error flag from data memory.
- `M_stat`, `M_icode`, `M_Cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM` out (3/4/1/64/64/4/4): registered fields.
- `mem_addr` out 64: data-memory address.
- `mem_read` out 1: load strobe.
- `mem_write` out 1: store strobe.
- `m_stat` out 3: memory-stage status to writeback and hazard unit.
- `m_frozen` out 1: sticky exception flag.

## Operation
- Register update priority each edge: `reset` > `M_stall` > `M_bubble` > normal load.
- Normal load: `M_*` ← corresponding `e_*`/`E_*` inputs.
- Bubble and reset value: `M_stat`=1 (AOK), `M_icode`=1 (NOP), `M_Cnd`=0, `M_valE`=0, `M_valA`=0, `M_dstE`=0xF, `M_dstM`=0xF; `m_frozen`=0 on reset only.
- Stall: all `M_*` hold; `m_frozen` still updates.
- Address select, combinational from `M_icode`:
  - `mem_addr`=`M_valE` for rmmovq(4), pushq(A), call(8), mrmovq(5).
  - `mem_addr`=`M_valA` for popq(B), ret(9).
  - Otherwise 0.
- `mem_read`=1 for mrmovq, popq, ret.
- Raw write = rmmovq, pushq, call.
- `mem_write` = raw write AND `M_stat`==AOK AND `W_stat`==AOK AND !`m_frozen`.
- `mem_read` and `mem_write` are never both 1.
- `m_stat`:
  - 3 (ADR) if (`mem_read` or raw write) and `dmem_error`.
  - Otherwise `M_stat`.
- `m_frozen` set on any edge where `m_stat` ∉ {AOK}. Cleared only by `reset`.

## Timing
- One-cycle latency: inputs present at edge N appear on `M_*`, `mem_*` after edge N.
- `mem_addr`, `mem_read`, `mem_write`, `m_stat` are combinational from registered state plus `W_stat`/`dmem_error`; no additional latency.
- `m_frozen` suppresses `mem_write` from the cycle after the faulting instruction leaves M. The faulting instruction itself is already suppressed when its `M_stat`≠AOK.
- `M_stall` and `M_bubble` both high: stall wins, with no bubble inserted.
- Reset mid-stall: bubble values loaded and `m_frozen` cleared on that edge.

## Configuration
- `MEM_ADDR_CHECK_EN` defined:
  - `mem_addr` ≥ `ADDR_LIMIT` on a read or raw write forces `m_stat`=ADR.
  - It also forces `mem_write`=0, independent of `dmem_error`.
- Undefined: address range is not checked; only `dmem_error` produces ADR.

## Test plan
- Reset sequence:
  - Stimulus: `reset`=1 for 2 cycles.
  - Required: `M_icode`=1, `M_stat`=1, `M_dstE`=`M_dstM`=0xF, `mem_read`=`mem_write`=0, `m_frozen`=0.
- rmmovq store:
  - Stimulus: load `E_icode`=4, `e_valE`=0x40, `E_valA`=0xDEAD.
  - Required: next cycle `mem_addr`=0x40, `M_valA`=0xDEAD, `mem_write`=1, `mem_read`=0.
- popq load:
  - Stimulus: `E_icode`=B, `E_valA`=0x100, `e_valE`=0x108.
  - Required: `mem_addr`=0x100, `mem_read`=1, `M_valE`=0x108.
- Stall vs bubble:
  - Stimulus: latch mrmovq, then assert `M_stall`=`M_bubble`=1.
  - Required: fields hold.
  - Stimulus: then `M_bubble` only.
  - Required: NOP bubble values.
- Exception freeze:
  - Stimulus: load popq with `dmem_error`=1.
  - Required: `m_stat`=3; `m_frozen`=1 next edge.
  - Stimulus: subsequent pushq.
  - Required: `mem_write`=0 until reset.
- Range check:
  - Stimulus: with `MEM_ADDR_CHECK_EN` defined, rmmovq to 0x2000 (`ADDR_LIMIT`=8192).
  - Required: `m_stat`=3, `mem_write`=0.
  - Stimulus: same store with the macro undefined.
  - Required: `mem_write`=1, `m_stat`=1.

Source files
------------

// File: rtl/memory_pipe_reg.sv
// memory_pipe_reg: E->M pipeline register and memory-stage control for the
// 5-stage Y86-64 pipeline. Latches execute results, honours stall/bubble from
// the hazard unit, drives data-memory address/strobes, folds the memory error
// into the stage status and blocks stores once an exception has been seen.
//
// Optional feature: define MEM_ADDR_CHECK_EN to flag any memory access whose
// address is >= ADDR_LIMIT as an address exception (ADR) and suppress the store.

module memory_pipe_reg #(
  parameter int ADDR_LIMIT = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] E_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [2:0]  W_stat,
  input  logic        dmem_error,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  m_stat,
  output logic        m_frozen
);

  // Status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  // Instruction codes that touch data memory
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic raw_write;
  logic addr_bad;

  // Pipeline register: reset > stall > bubble > normal load
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_stat  <= STAT_AOK;
        M_icode <= I_NOP;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= REG_NONE;
        M_dstM  <= REG_NONE;
      end else begin
        M_stat  <= e_stat;
        M_icode <= E_icode;
        M_Cnd   <= e_Cnd;
        M_valE  <= e_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
      end
    end
  end

  // Sticky exception flag: set by any non-AOK memory-stage status, even while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      m_frozen <= 1'b0;
    end else if (m_stat != STAT_AOK) begin
      m_frozen <= 1'b1;
    end
  end

  // Address select and access-type decode from the registered instruction
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    mem_addr  = '0;
    mem_read  = 1'b0;
    raw_write = 1'b0;
    unique case (M_icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: begin
        mem_addr  = M_valE;
        raw_write = 1'b1;
      end
      I_MRMOVQ: begin
        mem_addr = M_valE;
        mem_read = 1'b1;
      end
      I_POPQ, I_RET: begin
        mem_addr = M_valA;
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Range check only exists when the optional feature is compiled in
  assign addr_bad = RANGE_CHECK && (mem_read || raw_write) &&
                    (mem_addr >= 64'(ADDR_LIMIT));

  // Status merge and store gating; a store never proceeds behind an exception
  always_comb begin
    m_stat    = M_stat;
    mem_write = 1'b0;
    if ((mem_read || raw_write) && (dmem_error || addr_bad)) begin
      m_stat = STAT_ADR;
    end
    if (raw_write && (M_stat == STAT_AOK) && (W_stat == STAT_AOK) &&
        !m_frozen && !addr_bad) begin
      mem_write = 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_pipe_reg.sv
// tb_memory_pipe_reg: directed plus randomized checks of memory_pipe_reg
// against a behavioural model of the M register and memory-stage rules.

module tb_memory_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, M_stall, M_bubble, e_Cnd, dmem_error;
  logic [2:0]  e_stat, W_stat;
  logic [3:0]  E_icode, e_dstE, E_dstM;
  logic [63:0] e_valE, E_valA;
  logic [2:0]  M_stat, m_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd, mem_read, mem_write, m_frozen;
  logic [63:0] M_valE, M_valA, mem_addr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_pipe_reg #(.ADDR_LIMIT(8192)) dut (
    .clk(clk), .reset(reset), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_stat(e_stat), .E_icode(E_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
    .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM), .W_stat(W_stat),
    .dmem_error(dmem_error), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .m_stat(m_stat), .m_frozen(m_frozen)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  typedef struct {
    logic [63:0] addr;
    logic        rd;
    logic        wr;
    logic [2:0]  stat;
  } mout_t;

  mreg_t mdl;
  logic  mdl_frozen;

  function automatic mreg_t nop_bubble();
    mreg_t b;
    b.stat = 3'd1; b.icode = 4'h1; b.cnd = 1'b0; b.valE = '0; b.valA = '0;
    b.dstE = 4'hF; b.dstM = 4'hF;
    return b;
  endfunction

  function automatic mout_t predict(mreg_t r, logic frozen, logic [2:0] wst, logic derr);
    mout_t o;
    bit uses_valE, uses_valA, loads, stores, out_of_range;
    uses_valE = r.icode inside {4'h4, 4'hA, 4'h8, 4'h5};
    uses_valA = r.icode inside {4'hB, 4'h9};
    loads     = r.icode inside {4'h5, 4'hB, 4'h9};
    stores    = r.icode inside {4'h4, 4'hA, 4'h8};
    o.addr = uses_valE ? r.valE : (uses_valA ? r.valA : 64'd0);
    o.rd   = loads;
`ifdef MEM_ADDR_CHECK_EN
    out_of_range = (loads || stores) && (o.addr >= 64'd8192);
`else
    out_of_range = 1'b0;
`endif
    o.stat = ((loads || stores) && (derr || out_of_range)) ? 3'd3 : r.stat;
    o.wr   = stores && r.stat == 3'd1 && wst == 3'd1 && !frozen && !out_of_range;
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    mout_t o;
    o = predict(mdl, mdl_frozen, W_stat, dmem_error);
    check({tag, ".M_stat"},  64'(M_stat),  64'(mdl.stat));
    check({tag, ".M_icode"}, 64'(M_icode), 64'(mdl.icode));
    check({tag, ".M_Cnd"},   64'(M_Cnd),   64'(mdl.cnd));
    check({tag, ".M_valE"},  M_valE,       mdl.valE);
    check({tag, ".M_valA"},  M_valA,       mdl.valA);
    check({tag, ".M_dstE"},  64'(M_dstE),  64'(mdl.dstE));
    check({tag, ".M_dstM"},  64'(M_dstM),  64'(mdl.dstM));
    check({tag, ".addr"},    mem_addr,     o.addr);
    check({tag, ".rd"},      64'(mem_read),  64'(o.rd));
    check({tag, ".wr"},      64'(mem_write), 64'(o.wr));
    check({tag, ".m_stat"},  64'(m_stat),    64'(o.stat));
    check({tag, ".frozen"},  64'(m_frozen),  64'(mdl_frozen));
    check({tag, ".excl"},    64'(mem_read && mem_write), 64'(0));
  endtask

  // Advance the model across one edge with the current inputs, then the DUT.
  task automatic tick(input string tag);
    mout_t o;
    o = predict(mdl, mdl_frozen, W_stat, dmem_error);
    if (reset) begin
      mdl = nop_bubble();
      mdl_frozen = 1'b0;
    end else begin
      if (o.stat != 3'd1) mdl_frozen = 1'b1;
      if (!M_stall) begin
        if (M_bubble) mdl = nop_bubble();
        else begin
          mdl.stat = e_stat; mdl.icode = E_icode; mdl.cnd = e_Cnd;
          mdl.valE = e_valE; mdl.valA = E_valA; mdl.dstE = e_dstE; mdl.dstM = E_dstM;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic load(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    e_stat = 3'd1; E_icode = ic; e_valE = ve; E_valA = va;
    e_Cnd = 1'b1; e_dstE = 4'h3; E_dstM = 4'h7;
  endtask

  initial begin
    mdl = nop_bubble();
    mdl_frozen = 1'b0;
    reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; dmem_error = 1'b0; W_stat = 3'd1;
    load(4'h0, 64'h0, 64'h0);

    // Reset sequence
    tick("rst0");
    tick("rst1");
    check("rst.icode", 64'(M_icode), 64'd1);
    check("rst.dstM",  64'(M_dstM),  64'hF);
    check("rst.wr",    64'(mem_write), 64'd0);
    reset = 1'b0;

    // rmmovq store
    load(4'h4, 64'h40, 64'hDEAD);
    tick("rmmovq");
    check("rmmovq.addr", mem_addr, 64'h40);
    check("rmmovq.wr",   64'(mem_write), 64'd1);

    // W_stat not AOK blocks the store combinationally
    W_stat = 3'd2; #1;
    check_all("wstat_hlt");
    W_stat = 3'd1;

    // popq load
    load(4'hB, 64'h108, 64'h100);
    tick("popq");
    check("popq.addr", mem_addr, 64'h100);
    check("popq.rd",   64'(mem_read), 64'd1);

    // Stall beats bubble, then bubble alone
    load(4'h5, 64'h80, 64'h55);
    tick("mrmovq");
    load(4'h4, 64'h99, 64'h99);
    M_stall = 1'b1; M_bubble = 1'b1;
    tick("stall_bub");
    check("stall_bub.icode", 64'(M_icode), 64'h5);
    M_stall = 1'b0;
    tick("bubble");
    check("bubble.dstE", 64'(M_dstE), 64'hF);
    M_bubble = 1'b0;

    // Address boundary just below the limit, then at the limit
    load(4'h4, 64'h1FFF, 64'h1);
    tick("store_1fff");
    load(4'h4, 64'h2000, 64'h2);
    tick("store_2000");
`ifdef MEM_ADDR_CHECK_EN
    check("range.m_stat", 64'(m_stat), 64'd3);
    check("range.wr",     64'(mem_write), 64'd0);
`else
    check("range.m_stat", 64'(m_stat), 64'd1);
    check("range.wr",     64'(mem_write), 64'd1);
`endif
    reset = 1'b1; tick("rst2"); reset = 1'b0;

    // Exception freeze: popq faulting in memory, then stores stay blocked
    load(4'hB, 64'h18, 64'h10);
    tick("pop_err");
    dmem_error = 1'b1; #1;
    check_all("pop_err_comb");
    check("pop_err.m_stat", 64'(m_stat), 64'd3);
    load(4'hA, 64'h20, 64'h5);
    tick("push_after");
    dmem_error = 1'b0; #1;
    check("frozen.set", 64'(m_frozen), 64'd1);
    check_all("push_frozen");
    for (int i = 0; i < 3; i++) tick("push_frozen_n");
    M_stall = 1'b1;
    reset = 1'b1; tick("rst_mid_stall"); reset = 1'b0;
    M_stall = 1'b0;
    check("unfrozen", 64'(m_frozen), 64'd0);
    tick("push_unfrozen");
    check("push_unfrozen.wr", 64'(mem_write), 64'd1);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 29) == 0);
      M_stall    = ($urandom_range(0, 7) == 0);
      M_bubble   = ($urandom_range(0, 7) == 0);
      dmem_error = ($urandom_range(0, 15) == 0);
      W_stat     = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      e_stat     = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      E_icode    = 4'($urandom_range(0, 11));
      e_Cnd      = 1'($urandom);
      e_valE     = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 16383))
                                               : {$urandom, $urandom};
      E_valA     = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 16383))
                                               : {$urandom, $urandom};
      e_dstE     = 4'($urandom);
      E_dstM     = 4'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
